// File: rtl/bits2bytes_stream.sv
// Streaming bit packer: IN_W-bit words in, LSB-first byte stream out.
// An in_last_i word arms a flush that drains the remaining bits, zero-padding the last byte.
module bits2bytes_stream #(
  parameter int IN_W = 12
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [IN_W-1:0] in_data_i,
  input  logic            in_last_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [7:0]      out_data_o,
  output logic            out_last_o
);

  localparam int ACC_W = IN_W + 15;
  localparam int CNT_W = $clog2(ACC_W + 1);
  localparam logic [CNT_W-1:0] C0  = '0;
  localparam logic [CNT_W-1:0] C8  = CNT_W'(8);
  localparam logic [CNT_W-1:0] C15 = CNT_W'(15);
  localparam logic [CNT_W-1:0] CIN = CNT_W'(IN_W);

  logic [ACC_W-1:0] acc_q, acc_d, base;
  logic [CNT_W-1:0] cnt_q, cnt_d, n;
  logic             flush_q, flush_d;
  logic             in_fire, out_fire;

  // Ready is register-only so upstream never sees a combinational path from out_ready_i.
  assign in_ready_o  = !flush_q && (cnt_q <= C15);
  assign out_valid_o = (cnt_q >= C8) || (flush_q && (cnt_q != C0));
  assign out_last_o  = flush_q && (cnt_q <= C8) && (cnt_q != C0);
  assign out_data_o  = acc_q[7:0];

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  always_comb begin
    base    = out_fire ? (acc_q >> 8) : acc_q;
    n       = cnt_q;
    if (out_fire) n = (cnt_q > C8) ? (cnt_q - C8) : C0;
    acc_d   = base;
    cnt_d   = n;
    flush_d = flush_q;
    // New bits land just above the surviving ones; bits >= cnt stay zero, which pads the tail.
    if (in_fire) begin
      acc_d   = base | (ACC_W'(in_data_i) << n);
      cnt_d   = n + CIN;
      flush_d = flush_q | in_last_i;
    end
    if (out_fire && out_last_o) begin
      acc_d   = '0;
      cnt_d   = C0;
      flush_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      flush_q <= flush_d;
    end
  end

endmodule
